// File: rtl/usd_pkg.sv
// Shared definitions for the uSD card-side CMD responder.
// Contents: controller state enum, frame lengths, CRC7 polynomial, the ACMD41
// index and the fixed fields used by R2/R3 responses.
package usd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    EVAL,
    NCR,
    TX,
    TX_END
  } usd_state_e;

  localparam int unsigned CMD_LEN    = 48;
  localparam int unsigned R2_LEN     = 136;
  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [5:0]  ACMD41_IDX = 6'd41;

  // R2 and R3 carry all-ones in the index field; R3 also has an all-ones CRC field.
  localparam logic [5:0]  R_FIXED_IDX  = 6'h3F;
  localparam logic [6:0]  R3_FIXED_CRC = 7'h7F;

endpackage

// File: rtl/usd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one bit per clock.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clr        - synchronous clear to zero (wins over en)
//   en         - shift din into the CRC this cycle
//   din        - serial data bit, MSB of the message first
//   crc        - current CRC remainder
module usd_crc7
  import usd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  assign fb = din ^ crc_q[6];

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usd_card_cmd_responder.sv
// SD card CMD-line emulator: receives 48-bit host commands, checks framing and
// CRC7, reports good commands and answers with R1/R2/R3 after NCR idle cycles.
// Ports:
//   sdClk, sysRstN       - SD clock (rising edge) and async active-low reset
//   sdCmdIn              - CMD line sampled from the pad
//   sdCmdOut, sdCmdEn    - CMD drive value and active-high output enable
//   cardStatus, ocrReg   - R1 and R3 payloads, captured at response start
//   cidReg               - R2 payload; bits [7:1] hold a software CRC
//   cmdValid, crcErr     - one-cycle pulses for good / bad received frames
//   cmdIndex, cmdArg     - fields of the last good frame
//   busy                 - high whenever the controller is not idle
// Optional: define USD_RESP_CRC_INJECT_EN to add input injectCrcErr, which
// corrupts R1 CRC bit 0 or the R2/R3 end bit of the next response.
module usd_card_cmd_responder
  import usd_pkg::*;
#(
  parameter int unsigned NCR_CYCLES  = 2,
  parameter logic [63:0] R2_CMD_MASK = 64'h0000_0000_0000_0604
) (
  input  logic         sdClk,
  input  logic         sysRstN,
  input  logic         sdCmdIn,
  output logic         sdCmdOut,
  output logic         sdCmdEn,
  input  logic [31:0]  cardStatus,
  input  logic [31:0]  ocrReg,
  input  logic [127:0] cidReg,
`ifdef USD_RESP_CRC_INJECT_EN
  input  logic         injectCrcErr,
`endif
  output logic         cmdValid,
  output logic [5:0]   cmdIndex,
  output logic [31:0]  cmdArg,
  output logic         crcErr,
  output logic         busy
);

  usd_state_e   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [46:0]  rx_sr_q, rx_sr_d;
  logic [135:0] tx_sr_q, tx_sr_d;
  logic         r1_q, r1_d, r2_q, r2_d, inj_q, inj_d;
  logic         valid_q, valid_d, err_q, err_d;
  logic [5:0]   idx_q, idx_d;
  logic [31:0]  arg_q, arg_d;
  logic [6:0]   rx_crc, tx_crc;
  logic         frame_good, inject;
  logic [7:0]   tx_last;
  logic [2:0]   crc_sel;
  logic         unused_cid;

`ifdef USD_RESP_CRC_INJECT_EN
  assign inject = injectCrcErr;
`else
  assign inject = 1'b0;
`endif

  // cidReg[0] is replaced by the end bit.
  assign unused_cid = cidReg[0];

  // Receive checker: remainder is zero while idle, so the start bit adds nothing.
  usd_crc7 u_rx_crc (
    .clk   (sdClk),
    .rst_n (sysRstN),
    .clr   (state_q == IDLE),
    .en    ((state_q == RX) && (cnt_q < 8'd39)),
    .din   (sdCmdIn),
    .crc   (rx_crc)
  );

  // R1 generator: fed with the first 40 transmitted bits as they go out.
  usd_crc7 u_tx_crc (
    .clk   (sdClk),
    .rst_n (sysRstN),
    .clr   (state_q != TX),
    .en    ((state_q == TX) && (cnt_q < 8'd40)),
    .din   (tx_sr_q[135]),
    .crc   (tx_crc)
  );

  // rx_sr holds frame bits 46..0 once the end bit is in.
  assign frame_good = rx_sr_q[46] && rx_sr_q[0] && (rx_sr_q[7:1] == rx_crc);
  assign tx_last    = r2_q ? 8'(R2_LEN - 1) : 8'(CMD_LEN - 1);
  assign crc_sel    = 3'(8'd46 - cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_sr_d = rx_sr_q;
    tx_sr_d = tx_sr_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    inj_d   = inj_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    idx_d   = idx_q;
    arg_d   = arg_q;
    unique case (state_q)
      IDLE: begin
        if (!sdCmdIn) begin
          state_d = RX;
          cnt_d   = '0;
        end
      end
      RX: begin
        rx_sr_d = {rx_sr_q[45:0], sdCmdIn};
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'(CMD_LEN - 2)) state_d = EVAL;
      end
      EVAL: begin
        // EVAL is the first of the NCR idle cycles.
        cnt_d = '0;
        if (!frame_good) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
          idx_d   = rx_sr_q[45:40];
          arg_d   = rx_sr_q[39:8];
          state_d = (rx_sr_q[45:40] == 6'd0) ? IDLE : NCR;
        end
      end
      NCR: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(NCR_CYCLES - 2)) begin
          state_d = TX;
          cnt_d   = '0;
          inj_d   = inject;
          r1_d    = 1'b0;
          r2_d    = 1'b0;
          if (idx_q == ACMD41_IDX) begin
            tx_sr_d = {2'b00, R_FIXED_IDX, ocrReg, R3_FIXED_CRC, ~inject, 88'd0};
          end else if (R2_CMD_MASK[idx_q]) begin
            r2_d    = 1'b1;
            tx_sr_d = {2'b00, R_FIXED_IDX, cidReg[127:1], ~inject};
          end else begin
            // CRC field is substituted on the fly from u_tx_crc.
            r1_d    = 1'b1;
            tx_sr_d = {2'b00, idx_q, cardStatus, 7'd0, 1'b1, 88'd0};
          end
        end
      end
      TX: begin
        tx_sr_d = {tx_sr_q[134:0], 1'b0};
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == tx_last) state_d = TX_END;
      end
      TX_END: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sdCmdOut = 1'b1;
    sdCmdEn  = 1'b0;
    if (state_q == TX) begin
      sdCmdEn  = 1'b1;
      sdCmdOut = tx_sr_q[135];
      if (r1_q && (cnt_q >= 8'd40) && (cnt_q <= 8'd46)) begin
        sdCmdOut = tx_crc[crc_sel] ^ (inj_q && (cnt_q == 8'd46));
      end
    end
  end

  always_ff @(posedge sdClk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_sr_q <= '0;
      tx_sr_q <= '0;
      r1_q    <= 1'b0;
      r2_q    <= 1'b0;
      inj_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sr_q <= rx_sr_d;
      tx_sr_q <= tx_sr_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      inj_q   <= inj_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
    end
  end

  assign cmdValid = valid_q;
  assign crcErr   = err_q;
  assign cmdIndex = idx_q;
  assign cmdArg   = arg_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usd_card_cmd_responder.sv
// Directed bench for usd_card_cmd_responder: host frames are driven on the
// falling edge and all DUT outputs are sampled on the falling edge.
module tb_usd_card_cmd_responder;

  logic         sdClk = 1'b0;
  logic         sysRstN;
  logic         sdCmdIn;
  logic         sdCmdOut, sdCmdEn;
  logic [31:0]  cardStatus, ocrReg;
  logic [127:0] cidReg;
  logic         cmdValid, crcErr, busy;
  logic [5:0]   cmdIndex;
  logic [31:0]  cmdArg;

  int errors = 0;
  int checks = 0;

  usd_card_cmd_responder dut (
    .sdClk      (sdClk),
    .sysRstN    (sysRstN),
    .sdCmdIn    (sdCmdIn),
    .sdCmdOut   (sdCmdOut),
    .sdCmdEn    (sdCmdEn),
    .cardStatus (cardStatus),
    .ocrReg     (ocrReg),
    .cidReg     (cidReg),
    .cmdValid   (cmdValid),
    .cmdIndex   (cmdIndex),
    .cmdArg     (cmdArg),
    .crcErr     (crcErr),
    .busy       (busy)
  );

  always #5 sdClk = ~sdClk;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
  endfunction

  // Returns at the falling edge inside the EVAL cycle.
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sdClk);
      sdCmdIn = f[i];
    end
    @(negedge sdClk);
    sdCmdIn = 1'b1;
  endtask

  // Starts sampling at the current falling edge; en_ok drops if sdCmdEn is ever low.
  task automatic capture(input int n, output logic [135:0] r, output logic en_ok);
    r     = '0;
    en_ok = 1'b1;
    for (int i = n - 1; i >= 0; i--) begin
      if (i != n - 1) @(negedge sdClk);
      r[i] = sdCmdOut;
      if (sdCmdEn !== 1'b1) en_ok = 1'b0;
    end
  endtask

  task automatic watch_quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge sdClk);
      if (sdCmdEn !== 1'b0) seen = 1'b1;
    end
  endtask

  logic [135:0] resp;
  logic         en_ok, seen;
  logic [47:0]  r1_exp;
  logic [135:0] r2_exp;

  initial begin
    sysRstN    = 1'b0;
    sdCmdIn    = 1'b1;
    cardStatus = 32'h0;
    ocrReg     = 32'h0;
    cidReg     = 128'h0;
    #23;
    check("rst_out", 136'(sdCmdOut), 136'(1'b1));
    check("rst_en", 136'(sdCmdEn), 136'(1'b0));
    check("rst_valid", 136'(cmdValid), 136'(1'b0));
    check("rst_err", 136'(crcErr), 136'(1'b0));
    check("rst_idx", 136'(cmdIndex), 136'(6'd0));
    check("rst_arg", 136'(cmdArg), 136'(32'd0));
    check("rst_busy", 136'(busy), 136'(1'b0));
    @(negedge sdClk);
    sysRstN = 1'b1;
    repeat (3) @(negedge sdClk);

    // CMD0: reported, never answered.
    send_frame(48'h40_0000_0000_95);
    @(negedge sdClk);
    check("cmd0_valid", 136'(cmdValid), 136'(1'b1));
    check("cmd0_idx", 136'(cmdIndex), 136'(6'd0));
    check("cmd0_arg", 136'(cmdArg), 136'(32'd0));
    watch_quiet(200, seen);
    check("cmd0_no_resp", 136'(seen), 136'(1'b0));

    // CMD8 with corrupted final bit: error pulse, registers untouched.
    cardStatus = 32'h0000_0900;
    send_frame(48'h48_0000_01AA_86);
    @(negedge sdClk);
    check("bad_err", 136'(crcErr), 136'(1'b1));
    check("bad_valid", 136'(cmdValid), 136'(1'b0));
    check("bad_idx", 136'(cmdIndex), 136'(6'd0));
    check("bad_arg", 136'(cmdArg), 136'(32'd0));
    watch_quiet(60, seen);
    check("bad_no_resp", 136'(seen), 136'(1'b0));
    check("bad_busy", 136'(busy), 136'(1'b0));

    // CMD8: R1 after exactly two idle cycles.
    send_frame(48'h48_0000_01AA_87);
    check("cmd8_ncr1_en", 136'(sdCmdEn), 136'(1'b0));
    @(negedge sdClk);
    check("cmd8_valid", 136'(cmdValid), 136'(1'b1));
    check("cmd8_idx", 136'(cmdIndex), 136'(6'd8));
    check("cmd8_arg", 136'(cmdArg), 136'(32'h1AA));
    check("cmd8_ncr2_en", 136'(sdCmdEn), 136'(1'b0));
    @(negedge sdClk);
    cardStatus = 32'hFFFF_FFFF;
    capture(48, resp, en_ok);
    r1_exp = {2'b00, 6'd8, 32'h0000_0900, crc7_model({2'b00, 6'd8, 32'h0000_0900}), 1'b1};
    check("r1_en", 136'(en_ok), 136'(1'b1));
    check("r1_frame", 136'(resp[47:0]), 136'(r1_exp));
    @(negedge sdClk);
    check("r1_end_en", 136'(sdCmdEn), 136'(1'b0));
    check("r1_end_out", 136'(sdCmdOut), 136'(1'b1));
    @(negedge sdClk);
    check("r1_idle", 136'(busy), 136'(1'b0));

    // CMD2: 136-bit R2.
    cidReg = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    send_frame(make_cmd(6'd2, 32'h0));
    @(negedge sdClk);
    check("cmd2_idx", 136'(cmdIndex), 136'(6'd2));
    @(negedge sdClk);
    capture(136, resp, en_ok);
    r2_exp = {2'b00, 6'h3F, cidReg[127:1], 1'b1};
    check("r2_en", 136'(en_ok), 136'(1'b1));
    check("r2_hdr", 136'(resp[133:128]), 136'(6'h3F));
    check("r2_frame", resp, r2_exp);
    @(negedge sdClk);
    check("r2_end_en", 136'(sdCmdEn), 136'(1'b0));
    check("r2_end_busy", 136'(busy), 136'(1'b1));
    @(negedge sdClk);
    check("r2_idle", 136'(busy), 136'(1'b0));

    // ACMD41: R3 with fixed fields.
    ocrReg = 32'h80FF_8000;
    send_frame(make_cmd(6'd41, 32'h40FF_8000));
    repeat (2) @(negedge sdClk);
    capture(48, resp, en_ok);
    check("r3_en", 136'(en_ok), 136'(1'b1));
    check("r3_frame", 136'(resp[47:0]), 136'(48'h3F_80FF_8000_FF));
    repeat (3) @(negedge sdClk);

    // Reset 20 bits into an R2 response.
    send_frame(make_cmd(6'd2, 32'h0));
    repeat (2) @(negedge sdClk);
    repeat (20) @(negedge sdClk);
    check("mid_tx_en", 136'(sdCmdEn), 136'(1'b1));
    sysRstN = 1'b0;
    #1;
    check("rst_tx_en", 136'(sdCmdEn), 136'(1'b0));
    check("rst_tx_out", 136'(sdCmdOut), 136'(1'b1));
    check("rst_tx_busy", 136'(busy), 136'(1'b0));
    check("rst_tx_idx", 136'(cmdIndex), 136'(6'd0));
    @(negedge sdClk);
    sysRstN = 1'b1;
    repeat (2) @(negedge sdClk);
    send_frame(48'h40_0000_0000_95);
    @(negedge sdClk);
    check("post_rst_valid", 136'(cmdValid), 136'(1'b1));
    check("post_rst_idx", 136'(cmdIndex), 136'(6'd0));
    watch_quiet(20, seen);
    check("post_rst_quiet", 136'(seen), 136'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
